tm_warp_launcher: RTL and testbench

- Thread Manager stage directly upstream of the register allocation unit. Queues software-warp launch requests and binds each to a free hardware warp slot.
- Issues one register-allocation transaction at a time to the RAU, gated on the RAU's available-register count.
- Snoops IB exit events to release hardware slots and reports started warps to the issue logic.

---
 rtl/tm_pkg.sv | 31 +++
 rtl/tm_free_slot_pick.sv | 22 ++
 rtl/tm_warp_launcher.sv | 180 ++++++++++++++++++
 tb/tb_tm_warp_launcher.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_pkg.sv
// Shared widths, FSM encoding and launch-queue entry for the thread-manager warp launcher.
package tm_pkg;

   localparam int unsigned NUM_HW_WARPS = 8;
   localparam int unsigned HW_ID_W      = 3;
   localparam int unsigned SW_ID_W      = 32;
   localparam int unsigned NREQ_W       = 3;
   localparam int unsigned AVAIL_W      = 5;
   localparam int unsigned NEED_W       = AVAIL_W + 1;
   localparam int unsigned QDEPTH       = 4;
   localparam int unsigned QPTR_W       = $clog2(QDEPTH);
   localparam int unsigned QCNT_W       = QPTR_W + 1;
   localparam int unsigned STAT_W       = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b001,
      ST_ISSUE = 3'b010,
      ST_WAIT  = 3'b100
   } tm_state_e;

   typedef struct packed {
      logic [SW_ID_W-1:0] sw_warp;
      logic [NREQ_W-1:0]  nreq;
   } launch_entry_t;

   // RAU hands out registers in pairs, so an odd request costs one extra.
   function automatic logic [NEED_W-1:0] need_of(input logic [NREQ_W-1:0] nreq);
      return NEED_W'(nreq) + NEED_W'(nreq[0]);
   endfunction

endpackage

// File: rtl/tm_free_slot_pick.sv
// Lowest-index free hardware warp slot finder (combinational priority encoder).
module tm_free_slot_pick
   import tm_pkg::*;
(
   input  logic [NUM_HW_WARPS-1:0] i_active,
   output logic                    o_found_c,
   output logic [HW_ID_W-1:0]      o_id_c
);

   // Scan downward so the lowest free index is the last one written.
   always_comb begin
      o_found_c = 1'b0;
      o_id_c    = '0;
      for (int i = NUM_HW_WARPS - 1; i >= 0; i--) begin
         if (!i_active[i]) begin
            o_found_c = 1'b1;
            o_id_c    = HW_ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/tm_warp_launcher.sv
// Queues software-warp launches, binds them to free hardware slots and runs one RAU allocation at a time.
// Optional build macro TM_LAUNCH_STATS_EN adds launch_count and stall_cycles counters.
module tm_warp_launcher
   import tm_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    launch_valid,
   input  logic [SW_ID_W-1:0]      launch_sw_warp,
   input  logic [NREQ_W-1:0]       launch_nreq,
   output logic                    launch_ready,
   input  logic [AVAIL_W-1:0]      RAU_TM_Available,
   input  logic                    RAU_TM_AlloDone,
   input  logic                    IB_RAU_ExitEN,
   input  logic [HW_ID_W-1:0]      IB_Exit_WarpID,
   output logic                    TM_RAU_AlloEN,
   output logic [HW_ID_W-1:0]      TM_RAU_HWWarp,
   output logic [SW_ID_W-1:0]      TM_RAU_SWWarp,
   output logic [NREQ_W-1:0]       TM_RAU_Nreq,
   output logic [NUM_HW_WARPS-1:0] warp_active,
   output logic                    warp_start_valid,
   output logic [HW_ID_W-1:0]      warp_start_id
`ifdef TM_LAUNCH_STATS_EN
   ,
   output logic [STAT_W-1:0]       launch_count,
   output logic [STAT_W-1:0]       stall_cycles
`endif
);

   launch_entry_t             r_q [QDEPTH];
   logic [QPTR_W-1:0]         r_wr_ptr;
   logic [QPTR_W-1:0]         r_rd_ptr;
   logic [QCNT_W-1:0]         r_count;
   logic                      r_launch_ready;
   tm_state_e                 r_state;
   logic [NUM_HW_WARPS-1:0]   r_warp_active;
   logic                      r_allo_en;
   logic [HW_ID_W-1:0]        r_hw_warp;
   logic [SW_ID_W-1:0]        r_sw_warp;
   logic [NREQ_W-1:0]         r_nreq;
   logic                      r_start_valid;
   logic [HW_ID_W-1:0]        r_start_id;

   tm_state_e                 w_state_nxt;
   launch_entry_t             w_head;
   logic [NEED_W-1:0]         w_need;
   logic [QCNT_W-1:0]         w_count_nxt;
   logic                      w_empty;
   logic                      w_push;
   logic                      w_launch;
   logic                      w_can_launch;
   logic                      w_start_nxt;
   logic                      w_pick_found;
   logic [HW_ID_W-1:0]        w_pick_id;
   logic                      w_busy_slot;
   logic                      w_exit_ok;
   logic [NUM_HW_WARPS-1:0]   w_set_mask;
   logic [NUM_HW_WARPS-1:0]   w_clr_mask;

   tm_free_slot_pick u_pick (
      .i_active  (r_warp_active),
      .o_found_c (w_pick_found),
      .o_id_c    (w_pick_id)
   );

   assign w_empty      = (r_count == '0);
   assign w_push       = launch_valid && r_launch_ready;
   assign w_head       = r_q[r_rd_ptr];
   assign w_need       = need_of(w_head.nreq);
   assign w_can_launch = !w_empty && w_pick_found &&
                         (w_need <= NEED_W'(RAU_TM_Available)) && !IB_RAU_ExitEN;
   assign w_count_nxt  = r_count + QCNT_W'(w_push) - QCNT_W'(w_launch);

   // The slot bound to an in-flight allocation cannot be released by a snooped exit.
   assign w_busy_slot  = (r_state != ST_IDLE) && (IB_Exit_WarpID == r_hw_warp);
   assign w_exit_ok    = IB_RAU_ExitEN && r_warp_active[IB_Exit_WarpID] && !w_busy_slot;
   assign w_set_mask   = w_launch  ? (NUM_HW_WARPS'(1) << w_pick_id)      : '0;
   assign w_clr_mask   = w_exit_ok ? (NUM_HW_WARPS'(1) << IB_Exit_WarpID) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_start_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_can_launch) begin
               w_launch = 1'b1;
               if (w_need == '0) w_start_nxt = 1'b1;
               else              w_state_nxt = ST_ISSUE;
            end
         end
         // RAU ignores a request that coincides with an exit, so hold it.
         ST_ISSUE: begin
            if (!IB_RAU_ExitEN) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (RAU_TM_AlloDone) begin
               w_state_nxt = ST_IDLE;
               w_start_nxt = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_q[r_wr_ptr] <= '{sw_warp: launch_sw_warp, nreq: launch_nreq};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_launch_ready <= 1'b1;
      end else begin
         if (w_push)   r_wr_ptr <= r_wr_ptr + QPTR_W'(1);
         if (w_launch) r_rd_ptr <= r_rd_ptr + QPTR_W'(1);
         r_count        <= w_count_nxt;
         r_launch_ready <= (w_count_nxt != QCNT_W'(QDEPTH));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_warp_active <= '0;
         r_allo_en     <= 1'b0;
         r_hw_warp     <= '0;
         r_sw_warp     <= '0;
         r_nreq        <= '0;
         r_start_valid <= 1'b0;
         r_start_id    <= '0;
      end else begin
         r_warp_active <= (r_warp_active | w_set_mask) & ~w_clr_mask;
         r_allo_en     <= (w_state_nxt == ST_ISSUE);
         r_start_valid <= w_start_nxt;
         if (w_launch) begin
            r_hw_warp <= w_pick_id;
            r_sw_warp <= w_head.sw_warp;
            r_nreq    <= w_head.nreq;
         end
         if (w_start_nxt) r_start_id <= w_launch ? w_pick_id : r_hw_warp;
      end
   end

   assign launch_ready     = r_launch_ready;
   assign TM_RAU_AlloEN    = r_allo_en;
   assign TM_RAU_HWWarp    = r_hw_warp;
   assign TM_RAU_SWWarp    = r_sw_warp;
   assign TM_RAU_Nreq      = r_nreq;
   assign warp_active      = r_warp_active;
   assign warp_start_valid = r_start_valid;
   assign warp_start_id    = r_start_id;

`ifdef TM_LAUNCH_STATS_EN
   logic [STAT_W-1:0] r_launch_count;
   logic [STAT_W-1:0] r_stall_cycles;

   // Launch count wraps; stall count saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_launch_count <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (r_start_valid) r_launch_count <= r_launch_count + STAT_W'(1);
         if ((r_state == ST_IDLE) && !w_empty && !w_can_launch && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + STAT_W'(1);
      end
   end

   assign launch_count = r_launch_count;
   assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_tm_warp_launcher.sv
// Scoreboard bench for tm_warp_launcher: request-level slot model, RAU responder and decoupled monitor.
module tb_tm_warp_launcher;
   import tm_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    launch_valid;
   logic [SW_ID_W-1:0]      launch_sw_warp;
   logic [NREQ_W-1:0]       launch_nreq;
   logic                    launch_ready;
   logic [AVAIL_W-1:0]      RAU_TM_Available;
   logic                    RAU_TM_AlloDone;
   logic                    IB_RAU_ExitEN;
   logic [HW_ID_W-1:0]      IB_Exit_WarpID;
   logic                    TM_RAU_AlloEN;
   logic [HW_ID_W-1:0]      TM_RAU_HWWarp;
   logic [SW_ID_W-1:0]      TM_RAU_SWWarp;
   logic [NREQ_W-1:0]       TM_RAU_Nreq;
   logic [NUM_HW_WARPS-1:0] warp_active;
   logic                    warp_start_valid;
   logic [HW_ID_W-1:0]      warp_start_id;

   always #5 clk = ~clk;

   tm_warp_launcher dut (
      .clk              (clk),
      .rst              (rst),
      .launch_valid     (launch_valid),
      .launch_sw_warp   (launch_sw_warp),
      .launch_nreq      (launch_nreq),
      .launch_ready     (launch_ready),
      .RAU_TM_Available (RAU_TM_Available),
      .RAU_TM_AlloDone  (RAU_TM_AlloDone),
      .IB_RAU_ExitEN    (IB_RAU_ExitEN),
      .IB_Exit_WarpID   (IB_Exit_WarpID),
      .TM_RAU_AlloEN    (TM_RAU_AlloEN),
      .TM_RAU_HWWarp    (TM_RAU_HWWarp),
      .TM_RAU_SWWarp    (TM_RAU_SWWarp),
      .TM_RAU_Nreq      (TM_RAU_Nreq),
      .warp_active      (warp_active),
      .warp_start_valid (warp_start_valid),
      .warp_start_id    (warp_start_id)
   );

   typedef struct { int slot; logic [31:0] sw; int nreq; } exp_t;
   typedef struct { logic [31:0] sw; int nreq; } req_t;

   exp_t       exp_tx[$];
   int         exp_start[$];
   req_t       m_pend[$];
   logic [7:0] m_active = '0;
   int         n_vec = 0;
   int         n_err = 0;
   int         allo_cycles = 0;
   int         starts_seen = 0;
   bit         rau_hold = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: strict FIFO of requests; each takes the lowest free slot as soon as one exists.
   function automatic void model_assign();
      while (m_pend.size() > 0 && m_active != 8'hFF) begin
         int   slot = 0;
         req_t r;
         exp_t e;
         while (m_active[slot]) slot++;
         r = m_pend.pop_front();
         m_active[slot] = 1'b1;
         if (((r.nreq + 1) / 2) * 2 != 0) begin
            e.slot = slot; e.sw = r.sw; e.nreq = r.nreq;
            exp_tx.push_back(e);
         end
         exp_start.push_back(slot);
      end
   endfunction

   // Monitor: compares every accepted allocation and every start pulse against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (TM_RAU_AlloEN) allo_cycles++;
            if (TM_RAU_AlloEN && !IB_RAU_ExitEN) begin
               if (exp_tx.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_alloc: got hw=%0d none expected", TM_RAU_HWWarp);
               end else begin
                  e = exp_tx.pop_front();
                  check("alloc_hw",   64'(TM_RAU_HWWarp), 64'(e.slot));
                  check("alloc_sw",   64'(TM_RAU_SWWarp), 64'(e.sw));
                  check("alloc_nreq", 64'(TM_RAU_Nreq),   64'(e.nreq));
               end
            end
            if (warp_start_valid) begin
               starts_seen++;
               if (exp_start.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_start: got id=%0d none expected", warp_start_id);
               end else begin
                  check("start_id", 64'(warp_start_id), 64'(exp_start.pop_front()));
               end
            end
         end
      end
   end

   // RAU responder: acknowledges each accepted request after a random delay.
   initial begin
      int cnt = -1;
      RAU_TM_AlloDone = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) cnt = -1;
         else if (TM_RAU_AlloEN && !IB_RAU_ExitEN && !rau_hold) cnt = int'($urandom_range(0, 3));
         @(posedge clk);
         #1;
         RAU_TM_AlloDone = 1'b0;
         if (cnt == 0) begin
            RAU_TM_AlloDone = 1'b1;
            cnt = -1;
         end else if (cnt > 0) begin
            cnt--;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] sw, input int nreq, input int max_wait, output bit acc);
      acc            = 1'b0;
      launch_sw_warp = sw;
      launch_nreq    = NREQ_W'(nreq);
      launch_valid   = 1'b1;
      for (int i = 0; i < max_wait && !acc; i++) begin
         acc = launch_ready;
         tick();
      end
      launch_valid = 1'b0;
      if (acc) begin
         req_t r;
         r.sw = sw; r.nreq = nreq;
         m_pend.push_back(r);
         model_assign();
      end
   endtask

   task automatic quiesce();
      int i;
      for (i = 0; i < 300; i++) begin
         if (exp_tx.size() == 0 && exp_start.size() == 0) break;
         tick();
      end
      if (i == 300) begin
         n_vec++; n_err++;
         $display("FAIL quiesce_timeout: got %0d/%0d pending expected 0/0", exp_tx.size(), exp_start.size());
         exp_tx.delete();
         exp_start.delete();
      end
      tick();
      tick();
   endtask

   task automatic do_exit(input int id);
      IB_RAU_ExitEN  = 1'b1;
      IB_Exit_WarpID = HW_ID_W'(id);
      tick();
      IB_RAU_ExitEN  = 1'b0;
      if (m_active[id]) begin
         m_active[id] = 1'b0;
         model_assign();
      end
      quiesce();
   endtask

   task automatic wait_allo(input string name);
      int i;
      for (i = 0; i < 30; i++) begin
         if (TM_RAU_AlloEN) break;
         tick();
      end
      if (i == 30) begin
         n_vec++; n_err++;
         $display("FAIL %s: got no AlloEN expected AlloEN within 30 cycles", name);
      end
   endtask

   initial begin
      bit acc;
      int a0, s0, id;
      int lo_avail[2] = '{5, 7};
      int lo_nreq[2]  = '{5, 7};

      rst = 1'b1;
      launch_valid = 1'b0; launch_sw_warp = '0; launch_nreq = '0;
      RAU_TM_Available = AVAIL_W'(16);
      IB_RAU_ExitEN = 1'b0; IB_Exit_WarpID = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",  64'(launch_ready),     64'(1));
      check("rst_alloen", 64'(TM_RAU_AlloEN),    64'(0));
      check("rst_active", 64'(warp_active),      64'(0));
      check("rst_start",  64'(warp_start_valid), 64'(0));
      rst = 1'b0;
      tick();

      // Basic transaction into slot 0.
      a0 = allo_cycles;
      push(32'h100, 3, 5, acc);
      quiesce();
      check("basic_alloc_cycles", 64'(allo_cycles - a0), 64'(1));
      check("basic_active",       64'(warp_active),      64'(8'h01));

      // Available gating with pair rounding: odd request needs one extra register.
      for (int k = 0; k < 2; k++) begin
         RAU_TM_Available = AVAIL_W'(lo_avail[k]);
         a0 = allo_cycles;
         push(32'h200 + 32'(k), lo_nreq[k], 5, acc);
         repeat (6) tick();
         check("avail_blocked", 64'(allo_cycles - a0), 64'(0));
         RAU_TM_Available = AVAIL_W'(lo_avail[k] + 1);
         tick();
         check("avail_issue_next", 64'(TM_RAU_AlloEN), 64'(1));
         quiesce();
      end
      RAU_TM_Available = AVAIL_W'(16);

      // Exit strobe held across ISSUE, aimed at the in-flight slot (must be dropped).
      a0 = allo_cycles;
      s0 = starts_seen;
      push(32'h300, 2, 5, acc);
      wait_allo("issue_wait");
      IB_RAU_ExitEN = 1'b1; IB_Exit_WarpID = 3'd3;
      tick(); tick();
      IB_RAU_ExitEN = 1'b0;
      quiesce();
      check("exit_hold_cycles", 64'(allo_cycles - a0), 64'(3));
      check("exit_hold_starts", 64'(starts_seen - s0), 64'(1));
      check("exit_hold_active", 64'(warp_active),      64'(m_active));

      // Zero-register request starts without an RAU transaction.
      a0 = allo_cycles;
      push(32'h400, 0, 5, acc);
      quiesce();
      check("zero_no_alloc", 64'(allo_cycles - a0), 64'(0));

      // Fill all slots, then overfill the queue.
      for (int k = 5; k < 8; k++) push(32'h500 + 32'(k), int'($urandom_range(1, 7)), 5, acc);
      quiesce();
      check("full_active", 64'(warp_active), 64'(8'hFF));
      for (int k = 0; k < 4; k++) begin
         push(32'h600 + 32'(k), int'($urandom_range(0, 7)), 3, acc);
         check("fill_accept", 64'(acc), 64'(1));
      end
      check("full_ready", 64'(launch_ready), 64'(0));
      push(32'h6FF, 1, 4, acc);
      check("fifth_rejected", 64'(acc), 64'(0));
      do_exit(3);
      do_exit(0);
      do_exit(5);
      do_exit(6);
      check("refill_ready",  64'(launch_ready), 64'(1));
      check("refill_active", 64'(warp_active),  64'(m_active));

      // Randomized traffic with random exits (some to inactive slots).
      for (int it = 0; it < 40; it++) begin
         quiesce();
         while ($countones(m_active) >= 6) begin
            do id = int'($urandom_range(0, 7)); while (!m_active[id]);
            do_exit(id);
         end
         if ($urandom_range(0, 3) == 0) do_exit(int'($urandom_range(0, 7)));
         RAU_TM_Available = AVAIL_W'($urandom_range(8, 31));
         for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
            push($urandom(), int'($urandom_range(0, 7)), 10, acc);
            check("rand_accept", 64'(acc), 64'(1));
         end
      end
      quiesce();
      check("rand_active", 64'(warp_active), 64'(m_active));

      // Reset while waiting for the RAU, with a second request still queued.
      while ($countones(m_active) > 6) begin
         do id = int'($urandom_range(0, 7)); while (!m_active[id]);
         do_exit(id);
      end
      rau_hold = 1'b1;
      push(32'h700, 3, 5, acc);
      wait_allo("rst_wait");
      tick();
      push(32'h701, 1, 5, acc);
      #2 rst = 1'b1;
      #1;
      check("midrst_alloen", 64'(TM_RAU_AlloEN), 64'(0));
      check("midrst_active", 64'(warp_active),   64'(0));
      check("midrst_ready",  64'(launch_ready),  64'(1));
      check("midrst_hwwarp", 64'(TM_RAU_HWWarp), 64'(0));
      exp_tx.delete(); exp_start.delete(); m_pend.delete(); m_active = '0;
      tick();
      rst = 1'b0;
      rau_hold = 1'b0;
      a0 = allo_cycles;
      s0 = starts_seen;
      repeat (6) tick();
      check("postrst_no_alloc", 64'(allo_cycles - a0), 64'(0));
      check("postrst_no_start", 64'(starts_seen - s0), 64'(0));
      check("postrst_active",   64'(warp_active),      64'(0));
      push(32'h800, 4, 5, acc);
      quiesce();
      check("postrst_launch", 64'(warp_active), 64'(8'h01));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
